// File: rtl/prbs5_checker_pkg.sv
// ----------------------------------------------------------------------------
// prbs_pkg
// Definitions shared by the 5-bit PRBS generator and its receive-side checker.
//   PRBS_N        : LFSR length (only 5 is supported)
//   TAP_A / TAP_B : history taps that form the predicted next bit
//   GEN_SEED      : seed the generator starts from after reset
//   state_e       : checker FSM states FILL / SYNC / LOCKED
//   prbsPredict() : next-bit prediction from the 5-bit history
// ----------------------------------------------------------------------------
package prbs_pkg;

    localparam int PRBS_N = 5;
    localparam int TAP_A  = 0;
    localparam int TAP_B  = 2;

    localparam logic [PRBS_N-1:0] GEN_SEED = 5'b00001;

    // State encodings kept as plain constants so older code can still
    // compare against raw values; the enum below reuses them.
    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        FILL   = ST_FILL,
        SYNC   = ST_SYNC,
        LOCKED = ST_LOCKED
    } state_e;

    // h[0] is the oldest bit (r[n-5]) and h[2] is r[n-3], so this
    // implements r[n] = r[n-5] ^ r[n-3].
    function automatic logic prbsPredict(input logic [PRBS_N-1:0] h);
        return h[TAP_A] ^ h[TAP_B];
    endfunction

endpackage

// File: rtl/prbs5_checker_if.sv
// ----------------------------------------------------------------------------
// prbs5_checker_if
// Bit-stream input and status/counter output bundle of the PRBS5 checker.
//   in_valid     : in_bit is sampled only when high
//   in_bit       : received serial bit
//   clear_counts : synchronous clear of err_count and bit_count
//   locked       : checker is synchronised to the stream
//   err_pulse    : one-cycle pulse per mismatched bit while locked
//   err_count    : saturating error count while locked
//   bit_count    : saturating count of checked bits while locked
// Modports: master drives the stream (source side), slave is the checker.
// ----------------------------------------------------------------------------
interface prbs5_checker_if #(
    parameter int CNT_W = 16
);

    logic             in_valid;
    logic             in_bit;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output in_valid,
        output in_bit,
        output clear_counts,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  bit_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  clear_counts,
        output locked,
        output err_pulse,
        output err_count,
        output bit_count
    );

endinterface

// File: rtl/prbs5_checker_sat_counter.sv
// ----------------------------------------------------------------------------
// prbs_sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset (count -> 0)
//   clear_i  : synchronous clear, wins over inc_i
//   inc_i    : increment request
//   count_o  : current count
// ----------------------------------------------------------------------------
module prbs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority so a clear coinciding with an increment lands on 0.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs5_checker.sv
// ----------------------------------------------------------------------------
// prbs5_checker
// Self-synchronising receiver for the 5-bit LFSR stream r[n]=r[n-5]^r[n-3].
// Fills a 5-bit history from the line, waits for LOCK_COUNT consecutive
// correct predictions, then free-runs a local generator and counts every
// mismatch for BER measurement. Too many errors in one observation window
// drop the checker back to FILL to re-acquire.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : prbs5_checker_if.slave (stream in, status and counters out)
// ----------------------------------------------------------------------------
module prbs5_checker
    import prbs_pkg::*;
#(
    parameter int N           = 5,
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 32,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    prbs5_checker_if.slave bus
);

    localparam int FILL_W  = $clog2(N);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    state_e             state_q,   state_d;
    logic [N-1:0]       h_q,       h_d;
    logic [FILL_W-1:0]  fill_q,    fill_d;
    logic [MATCH_W-1:0] match_q,   match_d;
    logic [WIN_W-1:0]   winCnt_q,  winCnt_d;
    logic [WERR_W-1:0]  winErr_q,  winErr_d;
    logic               locked_q,  locked_d;
    logic               errPls_q,  errPls_d;

    logic               predicted;
    logic               mismatch;
    logic [WERR_W-1:0]  winErrNext;
    logic               errInc;
    logic               bitInc;
    logic [CNT_W-1:0]   errCount;
    logic [CNT_W-1:0]   bitCount;

    assign predicted  = prbsPredict(h_q);
    assign mismatch   = bus.in_bit ^ predicted;
    assign winErrNext = winErr_q + WERR_W'(mismatch);

    // Next-state logic. Nothing moves unless in_valid is high, so gapped
    // streams behave exactly like dense ones apart from timing.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        fill_d   = fill_q;
        match_d  = match_q;
        winCnt_d = winCnt_q;
        winErr_d = winErr_q;
        errPls_d = 1'b0;
        errInc   = 1'b0;
        bitInc   = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                FILL: begin
                    h_d = {bus.in_bit, h_q[N-1:1]};
                    if (fill_q == FILL_W'(N - 1)) begin
                        state_d = SYNC;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end

                SYNC: begin
                    h_d = {bus.in_bit, h_q[N-1:1]};
                    // An all-zero history predicts zeros forever, so it is
                    // never credited; a stuck-at-0 line therefore never locks.
                    if (!mismatch && (h_q != '0)) begin
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d  = LOCKED;
                            match_d  = '0;
                            winCnt_d = '0;
                            winErr_d = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
                    // Feed back the prediction rather than the line bit so a
                    // single channel error is counted once, not three times.
                    h_d      = {predicted, h_q[N-1:1]};
                    bitInc   = 1'b1;
                    errInc   = mismatch;
                    errPls_d = mismatch;
                    if (winErrNext >= WERR_W'(LOSS_THRESH)) begin
                        state_d = FILL;
                        h_d     = '0;
                        fill_d  = '0;
                    end else if (winCnt_q == WIN_W'(WINDOW - 1)) begin
                        winCnt_d = '0;
                        winErr_d = '0;
                    end else begin
                        winCnt_d = winCnt_q + WIN_W'(1);
                        winErr_d = winErrNext;
                    end
                end

                default: begin
                    state_d = FILL;
                    h_d     = '0;
                    fill_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers; locked and err_pulse are registered so all
    // outputs appear one cycle after the valid bit that caused them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FILL;
            h_q      <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            winCnt_q <= '0;
            winErr_q <= '0;
            locked_q <= 1'b0;
            errPls_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            winCnt_q <= winCnt_d;
            winErr_q <= winErr_d;
            locked_q <= locked_d;
            errPls_q <= errPls_d;
        end
    end

    prbs_sat_counter #(
        .W (CNT_W)
    ) u_err_count (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.clear_counts),
        .inc_i   (errInc),
        .count_o (errCount)
    );

    prbs_sat_counter #(
        .W (CNT_W)
    ) u_bit_count (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.clear_counts),
        .inc_i   (bitInc),
        .count_o (bitCount)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = errPls_q;
    assign bus.err_count = errCount;
    assign bus.bit_count = bitCount;

endmodule

// File: tb/tb_prbs5_checker.sv
// ----------------------------------------------------------------------------
// tb_prbs5_checker
// Directed bench for prbs5_checker: lock acquisition, single error, loss of
// lock and re-lock, counter clear against an error, asynchronous reset while
// locked, gapped valid, and a stuck-at-0 line.
// ----------------------------------------------------------------------------
module tb_prbs5_checker;

    localparam int CNT_W = 16;

    // One period of the generator output from seed 00001, r[0] leftmost.
    localparam logic [0:30] PRBS_SEQ = 31'b1000010010110011111000110111010;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;
    int   seqIdx     = 0;

    prbs5_checker_if #(.CNT_W(CNT_W)) bus ();

    prbs5_checker #(
        .N           (5),
        .LOCK_COUNT  (16),
        .WINDOW      (32),
        .LOSS_THRESH (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs and return 1 time unit after the clock edge.
    task automatic applyStimulus(input logic valid, input logic bitVal, input logic clr);
        bus.in_valid     = valid;
        bus.in_bit       = bitVal;
        bus.clear_counts = clr;
        @(posedge clk);
        #1;
    endtask

    // Send the next generator bit, optionally inverted, and advance the stream.
    task automatic sendPrbs(input logic flip, input logic clr);
        applyStimulus(1'b1, PRBS_SEQ[seqIdx] ^ flip, clr);
        seqIdx = (seqIdx == 30) ? 0 : seqIdx + 1;
    endtask

    initial begin
        int pulses;
        int lockedSeen;

        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.clear_counts = 1'b0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_locked", bus.locked, 0);
        checkOutput("reset_err_pulse", bus.err_pulse, 0);
        checkOutput("reset_err_count", bus.err_count, 0);
        checkOutput("reset_bit_count", bus.bit_count, 0);
        reset = 1'b1;

        $display("[TB] lock acquisition");
        repeat (20) sendPrbs(1'b0, 1'b0);
        checkOutput("lock_not_early", bus.locked, 0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("lock_after_21", bus.locked, 1);
        checkOutput("lock_err_count", bus.err_count, 0);
        checkOutput("lock_bit_count", bus.bit_count, 0);

        $display("[TB] single error");
        repeat (3) sendPrbs(1'b0, 1'b0);
        checkOutput("clean_bit_count", bus.bit_count, 3);
        sendPrbs(1'b1, 1'b0);
        checkOutput("single_pulse", bus.err_pulse, 1);
        checkOutput("single_err_count", bus.err_count, 1);
        checkOutput("single_bit_count", bus.bit_count, 4);
        checkOutput("single_locked", bus.locked, 1);
        pulses = 0;
        repeat (11) begin
            sendPrbs(1'b0, 1'b0);
            pulses += int'(bus.err_pulse);
        end
        checkOutput("single_no_more_pulses", pulses, 0);
        checkOutput("single_err_hold", bus.err_count, 1);
        checkOutput("single_bit_count_15", bus.bit_count, 15);

        // Finish the first 32-bit window so the earlier error is forgotten.
        repeat (17) sendPrbs(1'b0, 1'b0);
        checkOutput("window_bit_count_32", bus.bit_count, 32);
        sendPrbs(1'b0, 1'b1);
        checkOutput("clear_wins_bits", bus.bit_count, 0);
        checkOutput("clear_err_count", bus.err_count, 0);

        $display("[TB] loss of lock");
        for (int e = 0; e < 3; e++) begin
            sendPrbs(1'b1, 1'b0);
            checkOutput("loss_still_locked", bus.locked, 1);
            sendPrbs(1'b0, 1'b0);
        end
        sendPrbs(1'b1, 1'b0);
        checkOutput("loss_locked_falls", bus.locked, 0);
        checkOutput("loss_err_pulse", bus.err_pulse, 1);
        checkOutput("loss_err_count", bus.err_count, 4);
        checkOutput("loss_bit_count", bus.bit_count, 7);

        $display("[TB] re-lock");
        repeat (20) sendPrbs(1'b0, 1'b0);
        checkOutput("relock_not_early", bus.locked, 0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("relock_after_21", bus.locked, 1);
        checkOutput("relock_err_kept", bus.err_count, 4);
        checkOutput("relock_bits_kept", bus.bit_count, 7);

        $display("[TB] clear with error");
        sendPrbs(1'b1, 1'b1);
        checkOutput("clear_err_pulse", bus.err_pulse, 1);
        checkOutput("clear_over_err", bus.err_count, 0);
        checkOutput("clear_over_bits", bus.bit_count, 0);
        sendPrbs(1'b1, 1'b0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("pre_reset_err", bus.err_count, 1);
        checkOutput("pre_reset_bits", bus.bit_count, 2);
        checkOutput("pre_reset_locked", bus.locked, 1);

        $display("[TB] asynchronous reset");
        reset = 1'b0;
        #2;
        checkOutput("async_locked", bus.locked, 0);
        checkOutput("async_err_count", bus.err_count, 0);
        checkOutput("async_bit_count", bus.bit_count, 0);
        reset = 1'b1;

        $display("[TB] gapped valid");
        for (int v = 1; v <= 21; v++) begin
            applyStimulus(1'b0, ~PRBS_SEQ[seqIdx], 1'b0);
            sendPrbs(1'b0, 1'b0);
            if (v == 20) checkOutput("gap_not_early", bus.locked, 0);
        end
        checkOutput("gap_locked", bus.locked, 1);
        applyStimulus(1'b0, ~PRBS_SEQ[seqIdx], 1'b0);
        checkOutput("gap_idle_pulse", bus.err_pulse, 0);
        checkOutput("gap_idle_bits", bus.bit_count, 0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("gap_bit_count", bus.bit_count, 1);
        checkOutput("gap_err_count", bus.err_count, 0);

        $display("[TB] stuck-at-0 line");
        reset = 1'b0;
        #2;
        reset = 1'b1;
        lockedSeen = 0;
        repeat (200) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (bus.locked) lockedSeen++;
        end
        checkOutput("stuck_never_locked", lockedSeen, 0);
        checkOutput("stuck_err_count", bus.err_count, 0);
        checkOutput("stuck_bit_count", bus.bit_count, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/prbs5_checker.md
Name: prbs5_checker

Overview:
- Receive-side counterpart of the team's 5-bit LFSR pattern generator.
- Takes the serial bit stream the generator emits (generator q[0] each step), self-synchronises to it, then flags and counts bit errors for BER measurement.
- Sits after the channel/demodulator; one valid-qualified bit per clock at most.

Parameters:
- N, 5, LFSR length; only 5 supported; recurrence r[n] = r[n-5] ^ r[n-3], period 31.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- WINDOW, 32, valid bits per loss-of-lock observation window.
- LOSS_THRESH, 4, errors within one window that force loss of lock.
- CNT_W, 16, width of the error and bit counters.

Ports:
- clk, input, 1, single clock; all logic rising-edge.
- reset, input, 1, asynchronous, active-low reset (fixed polarity/synchronicity).
- in_valid, input, 1, in_bit is sampled only when high.
- in_bit, input, 1, received serial bit.
- clear_counts, input, 1, synchronous clear of err_count and bit_count.
- locked, output, 1, checker is synchronised.
- err_pulse, output, 1, one-cycle pulse per mismatched bit while locked.
- err_count, output, CNT_W, saturating count of errors while locked.
- bit_count, output, CNT_W, saturating count of valid bits checked while locked.

Behaviour:
- Reset (reset low, asynchronous):
  - State FILL, history h = 0, all counters 0.
  - locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
- History register h[4:0]: on each valid bit, h <= {bit, h[4:1]}.
- Predicted next bit p = h[0] ^ h[2].
- Only cycles with in_valid = 1 advance any state or counter. err_pulse is 0 on every cycle without a valid mismatch.
- FILL:
  - Shift in received bits; fill counter counts 0..4.
  - After the 5th valid bit, go to SYNC with match_cnt = 0.
- SYNC:
  - Shift in received bits.
  - If in_bit == p and h != 0: match_cnt++. Otherwise match_cnt = 0.
  - An all-zero h never counts as a match, so a stuck-at-0 line cannot lock.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED, clear the window counters. locked rises in the cycle after that valid bit.
- LOCKED:
  - h shifts in p, not in_bit (free-running local generator), so one channel error yields exactly one error.
  - On in_bit != p: err_pulse = 1 in the next cycle, err_count++ (saturating), win_err++.
  - bit_count++ (saturating) on every valid bit.
  - win_cnt counts valid bits modulo WINDOW.
  - If win_err reaches LOSS_THRESH, including on the erroring bit itself: go to FILL next cycle, locked falls, h is cleared. Counters are preserved.
  - When win_cnt wraps without reaching threshold: win_err = 0.
- Counters: err_count and bit_count saturate at all-ones and never wrap.
- clear_counts:
  - When asserted, both counters become 0 next cycle.
  - Clear wins over a simultaneous increment: the result is 0, not 1.
  - err_pulse is still generated.
- Latency: all outputs registered; one cycle from the valid input bit.
- Reset mid-operation takes effect immediately, in any state.

Decomposition:
- Package prbs_pkg:
  - State enum {FILL, SYNC, LOCKED}.
  - Constants PRBS_N = 5, TAP_A = 0, TAP_B = 2 (shared with the generator).
  - Generator seed 5'b00001.
- One sub-module, prbs_sat_counter: CNT_W-wide saturating counter with inc and synchronous clear, clear priority. Instantiated for err_count and bit_count.

Test Plan:
- Lock acquisition:
  - Stimulus: generator stream from seed 00001 (1,0,0,0,0,1,...), in_valid = 1 continuously.
  - Required: locked = 1 in the cycle after the 21st valid bit (5 fill + 16 matches), err_count = 0.
- Single error:
  - Stimulus: after lock, invert exactly one bit.
  - Required: one err_pulse, err_count = 1, locked stays 1, no further pulses; bit_count keeps incrementing.
- Stuck line:
  - Stimulus: 200 valid zeros.
  - Required: locked = 0 throughout, err_count = 0, bit_count = 0.
- Loss of lock:
  - Stimulus: after lock, invert 4 bits within 32 valid bits.
  - Required: locked falls one cycle after the 4th error, err_count = 4.
  - Then a clean stream re-locks after 21 further valid bits.
- Gapped valid:
  - Stimulus: in_valid toggles every cycle on the clean stream.
  - Required: lock after 21 valid bits (about 42 cycles), zero errors.
- Clear and reset:
  - Stimulus: clear_counts in the same cycle as an error bit.
  - Required: err_count = 0; err_pulse still asserted.
  - Stimulus: assert reset while locked.
  - Required: locked, err_count, bit_count = 0 immediately, without waiting for a clock edge.
